counter_step_decoder: RTL and testbench



---
 rtl/counter_pkg.sv | 19 +
 rtl/counter_step_decoder_step_decode.sv | 33 +++
 rtl/counter_step_decoder.sv | 143 ++++++++++++++
 tb/tb_counter_step_decoder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants for the counter sel/Q interface: sel codes, step sizes
// and the decoder FSM state encoding.
package counter_pkg;

    localparam logic [1:0] SEL_INC1 = 2'b00;
    localparam logic [1:0] SEL_INC2 = 2'b01;
    localparam logic [1:0] SEL_INC4 = 2'b10;
    localparam logic [1:0] SEL_RST  = 2'b11;

    localparam logic [2:0] STEP_INC1 = 3'd1;
    localparam logic [2:0] STEP_INC2 = 3'd2;
    localparam logic [2:0] STEP_INC4 = 3'd4;

    typedef enum logic {
        UNSYNC = 1'b0,
        TRACK  = 1'b1
    } state_e;

endpackage

// File: rtl/counter_step_decoder_step_decode.sv
// Combinational step classifier: maps a q_prev -> q_in transition onto the
// sel code that produced it. Add steps take priority over the force-to-zero
// code, so 7->0, 6->0 and 4->0 decode as +1, +2 and +4.
module step_decode
    import counter_pkg::*;
(
    input  logic [2:0] q_prev_i,
    input  logic [2:0] q_in_i,
    output logic [1:0] sel_code_o,
    output logic       legal_o
);

    logic [2:0] delta;

    // Modulo-8 delta followed by the fixed decode priority.
    always_comb begin
        delta      = q_in_i - q_prev_i;
        sel_code_o = SEL_INC1;
        legal_o    = 1'b1;
        if (delta == STEP_INC1) begin
            sel_code_o = SEL_INC1;
        end else if (delta == STEP_INC2) begin
            sel_code_o = SEL_INC2;
        end else if (delta == STEP_INC4) begin
            sel_code_o = SEL_INC4;
        end else if (q_in_i == 3'd0) begin
            sel_code_o = SEL_RST;
        end else begin
            legal_o = 1'b0;
        end
    end

endmodule

// File: rtl/counter_step_decoder.sv
// Decoding end of the counter sel/Q interface. Tracks the Q stream, emits the
// recovered sel code per transition, flags illegal steps with a saturating
// error count and drops sync after MAX_CONSEC_ERR consecutive errors.
// Optional build macro STEP_HIST_EN adds four 16-bit saturating per-code
// tallies (hist_00..hist_11) of decoded transitions.
module counter_step_decoder
    import counter_pkg::*;
#(
    parameter int unsigned ERR_CNT_W      = 8,
    parameter int unsigned MAX_CONSEC_ERR = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2:0]           q_in,
    input  logic                 q_valid,
    output logic [1:0]           sel_out,
    output logic                 sel_valid,
    output logic                 step_err,
    output logic                 synced,
    output logic [ERR_CNT_W-1:0] err_count
`ifdef STEP_HIST_EN
    ,
    output logic [15:0]          hist_00,
    output logic [15:0]          hist_01,
    output logic [15:0]          hist_10,
    output logic [15:0]          hist_11
`endif
);

    localparam logic [2:0] MAX_C = 3'(MAX_CONSEC_ERR);

    state_e                 state_q, state_d;
    logic [2:0]             q_prev_q, q_prev_d;
    logic [2:0]             consec_q, consec_d;
    logic [ERR_CNT_W-1:0]   err_q, err_d;
    logic [1:0]             sel_q, sel_d;
    logic                   sel_valid_q, sel_valid_d;
    logic                   step_err_q, step_err_d;

    logic [1:0]             dec_sel;
    logic                   dec_legal;

    step_decode u_step_decode (
        .q_prev_i   (q_prev_q),
        .q_in_i     (q_in),
        .sel_code_o (dec_sel),
        .legal_o    (dec_legal)
    );

    // Next-state and registered-output logic for the UNSYNC/TRACK FSM.
    always_comb begin
        state_d     = state_q;
        q_prev_d    = q_prev_q;
        consec_d    = consec_q;
        err_d       = err_q;
        sel_d       = sel_q;
        sel_valid_d = 1'b0;
        step_err_d  = 1'b0;
        case (state_q)
            UNSYNC: begin
                consec_d = '0;
                if (q_valid) begin
                    q_prev_d = q_in;
                    state_d  = TRACK;
                end
            end
            TRACK: begin
                if (!q_valid) begin
                    state_d = UNSYNC;
                end else begin
                    q_prev_d = q_in;
                    if (dec_legal) begin
                        sel_d       = dec_sel;
                        sel_valid_d = 1'b1;
                        consec_d    = '0;
                    end else begin
                        step_err_d = 1'b1;
                        if (err_q != '1) begin
                            err_d = err_q + 1'b1;
                        end
                        // Leave TRACK on the same edge that records the
                        // MAX-th error so the following sample re-arms.
                        if (consec_q + 3'd1 >= MAX_C) begin
                            state_d  = UNSYNC;
                            consec_d = '0;
                        end else begin
                            consec_d = consec_q + 3'd1;
                        end
                    end
                end
            end
            default: state_d = UNSYNC;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= UNSYNC;
            q_prev_q    <= '0;
            consec_q    <= '0;
            err_q       <= '0;
            sel_q       <= SEL_INC1;
            sel_valid_q <= 1'b0;
            step_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            q_prev_q    <= q_prev_d;
            consec_q    <= consec_d;
            err_q       <= err_d;
            sel_q       <= sel_d;
            sel_valid_q <= sel_valid_d;
            step_err_q  <= step_err_d;
        end
    end

    assign sel_out   = sel_q;
    assign sel_valid = sel_valid_q;
    assign step_err  = step_err_q;
    assign synced    = (state_q == TRACK);
    assign err_count = err_q;

`ifdef STEP_HIST_EN
    logic [15:0] hist_q [4];

    // Per-code saturating tallies, updated alongside the sel_valid pulse.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (rst) begin
                hist_q[i] <= '0;
            end else if (sel_valid_d && (sel_d == 2'(i)) && (hist_q[i] != '1)) begin
                hist_q[i] <= hist_q[i] + 16'd1;
            end
        end
    end

    assign hist_00 = hist_q[0];
    assign hist_01 = hist_q[1];
    assign hist_10 = hist_q[2];
    assign hist_11 = hist_q[3];
`endif

endmodule

// File: tb/tb_counter_step_decoder.sv
// Self-checking bench for counter_step_decoder: a behavioural model predicts
// the registered outputs for each driven sample; predictions are queued and
// compared one clock later. Build with STEP_HIST_EN to also cover hist_*.
module tb_counter_step_decoder;

    localparam int unsigned ERR_W = 8;
    localparam int unsigned MAXC  = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       q_in;
    logic             q_valid;
    logic [1:0]       sel_out;
    logic             sel_valid;
    logic             step_err;
    logic             synced;
    logic [ERR_W-1:0] err_count;
`ifdef STEP_HIST_EN
    logic [15:0]      hist_00, hist_01, hist_10, hist_11;
`endif

    always #5 clk = ~clk;

    counter_step_decoder #(
        .ERR_CNT_W      (ERR_W),
        .MAX_CONSEC_ERR (MAXC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .q_in      (q_in),
        .q_valid   (q_valid),
        .sel_out   (sel_out),
        .sel_valid (sel_valid),
        .step_err  (step_err),
        .synced    (synced),
        .err_count (err_count)
`ifdef STEP_HIST_EN
        ,
        .hist_00   (hist_00),
        .hist_01   (hist_01),
        .hist_10   (hist_10),
        .hist_11   (hist_11)
`endif
    );

    typedef struct {
        logic [1:0] sel;
        logic       chk_sel;
        logic       sel_valid;
        logic       step_err;
        logic       synced;
        logic [7:0] err;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Model state
    bit          m_track  = 1'b0;
    logic [2:0]  m_prev   = 3'd0;
    int unsigned m_consec = 0;
    int unsigned m_err    = 0;
    logic [1:0]  m_sel    = 2'b00;
    int unsigned m_hist [4] = '{0, 0, 0, 0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Forward model: try each counter step from p and see which lands on c.
    function automatic void ref_decode(input logic [2:0] p, input logic [2:0] c,
                                       output logic [1:0] sel, output bit ok);
        logic [2:0] n1, n2, n4;
        n1 = p + 3'd1;
        n2 = p + 3'd2;
        n4 = p + 3'd4;
        ok  = 1'b1;
        sel = 2'b00;
        if      (c == n1)   sel = 2'b00;
        else if (c == n2)   sel = 2'b01;
        else if (c == n4)   sel = 2'b10;
        else if (c == 3'd0) sel = 2'b11;
        else                ok  = 1'b0;
    endfunction

    task automatic drive(input string tag, input logic r, input logic v, input logic [2:0] q);
        exp_t       e;
        exp_t       o;
        logic [1:0] s;
        bit         ok;
        e.sel_valid = 1'b0;
        e.step_err  = 1'b0;
        e.chk_sel   = 1'b0;
        if (r) begin
            m_track = 1'b0; m_prev = 3'd0; m_consec = 0; m_err = 0; m_sel = 2'b00;
            for (int i = 0; i < 4; i++) m_hist[i] = 0;
            e.chk_sel = 1'b1;
        end else if (!m_track) begin
            m_consec = 0;
            if (v) begin
                m_prev  = q;
                m_track = 1'b1;
            end
        end else if (!v) begin
            m_track = 1'b0;
        end else begin
            ref_decode(m_prev, q, s, ok);
            if (ok) begin
                m_sel       = s;
                e.sel_valid = 1'b1;
                e.chk_sel   = 1'b1;
                m_consec    = 0;
                m_hist[s]++;
            end else begin
                e.step_err = 1'b1;
                if (m_err < 255) m_err++;
                m_consec++;
                if (m_consec >= MAXC) begin
                    m_track  = 1'b0;
                    m_consec = 0;
                end
            end
            m_prev = q;
        end
        e.sel    = m_sel;
        e.synced = m_track;
        e.err    = 8'(m_err);
        sb.push_back(e);

        rst     = r;
        q_valid = v;
        q_in    = q;
        @(posedge clk);
        #1;
        o = sb.pop_front();
        check({tag, ".sel_valid"}, 32'(sel_valid), 32'(o.sel_valid));
        check({tag, ".step_err"},  32'(step_err),  32'(o.step_err));
        check({tag, ".synced"},    32'(synced),    32'(o.synced));
        check({tag, ".err_count"}, 32'(err_count), 32'(o.err));
        if (o.chk_sel) check({tag, ".sel_out"}, 32'(sel_out), 32'(o.sel));
    endtask

    initial begin
        rst = 1'b1; q_valid = 1'b0; q_in = 3'd0;

        drive("reset", 1'b1, 1'b0, 3'd0);
        drive("reset", 1'b1, 1'b0, 3'd0);

        // Sync on 0 then +1, +2, +4 and the ambiguous 7->0 (+1)
        drive("s1", 1'b0, 1'b1, 3'd0);
        drive("s1", 1'b0, 1'b1, 3'd1);
        drive("s1", 1'b0, 1'b1, 3'd3);
        drive("s1", 1'b0, 1'b1, 3'd7);
        drive("s1", 1'b0, 1'b1, 3'd0);
        check("s1_sel_last", 32'(sel_out), 32'd0);
`ifdef STEP_HIST_EN
        check("hist_00", 32'(hist_00), 32'd2);
        check("hist_01", 32'(hist_01), 32'd1);
        check("hist_10", 32'(hist_10), 32'd1);
        check("hist_11", 32'(hist_11), 32'd0);
`endif

        // 3->5 (+2), 5->0 force-to-zero
        drive("gap", 1'b0, 1'b0, 3'd0);
        drive("s2", 1'b0, 1'b1, 3'd3);
        drive("s2", 1'b0, 1'b1, 3'd5);
        drive("s2", 1'b0, 1'b1, 3'd0);
        check("s2_sel_rst", 32'(sel_out), 32'd3);

        // Three consecutive illegal steps drop sync; the next sample re-arms
        drive("gap", 1'b0, 1'b0, 3'd0);
        drive("s3", 1'b0, 1'b1, 3'd2);
        drive("s3", 1'b0, 1'b1, 3'd5);
        drive("s3", 1'b0, 1'b1, 3'd5);
        drive("s3", 1'b0, 1'b1, 3'd5);
        check("s3_unsync", 32'(synced), 32'd0);
        drive("s3", 1'b0, 1'b1, 3'd5);
        check("s3_resync", 32'(synced), 32'd1);
        check("s3_errs", 32'(err_count), 32'd3);
        drive("s3", 1'b0, 1'b1, 3'd6);

        // One-cycle q_valid drop, then re-sync and decode
        drive("s4", 1'b0, 1'b1, 3'd7);
        drive("s4", 1'b0, 1'b0, 3'd3);
        drive("s4", 1'b0, 1'b1, 3'd2);
        drive("s4", 1'b0, 1'b1, 3'd4);

        // Push err_count to 5, then reset in TRACK
        drive("s5", 1'b0, 1'b1, 3'd7);
        drive("s5", 1'b0, 1'b1, 3'd7);
        check("s5_err_before_rst", 32'(err_count), 32'd5);
        drive("s5", 1'b1, 1'b1, 3'd3);
        check("s5_err_after_rst", 32'(err_count), 32'd0);
        drive("s5", 1'b0, 1'b1, 3'd4);

        // Saturation: repeated 5->5 (about 300 errors)
        for (int i = 0; i < 400; i++) drive("s6", 1'b0, 1'b1, 3'd5);
        check("s6_saturated", 32'(err_count), 32'd255);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
